matrix_streamer: RTL and testbench

Transmit-side counterpart of the matrix loader. Accepts matrix rows as 256-bit words over a valid/ready handshake, then serializes them onto the Ethernet-side 2-bit dibit bus (`axiov`/`axiod`) in the `eth_refclk` domain. It sits between the result row source (result BRAM reader or systolic output collector) and the Ethernet TX framer. A staging register keeps consecutive rows gap-free, so each row emits 128 dibits back-to-back.

---
 rtl/matrix_pkg.sv | 16 +
 rtl/row_serializer.sv | 54 +++++
 rtl/matrix_streamer.sv | 147 ++++++++++++++
 tb/tb_matrix_streamer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types and default sizes for the matrix streaming path.
// Imported by matrix_streamer and row_serializer.
package matrix_pkg;

  localparam int DEF_ELEMENT_SIZE = 8;
  localparam int DEF_ROW_LEN      = 32;
  localparam int DEF_NUM_ROWS     = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } stream_state_t;

  typedef logic [1:0] dibit_t;

endpackage

// File: rtl/row_serializer.sv
// Row shifter: loads one RW-bit row and emits it MSB dibit first.
// Ports: clk/rst_n, i_load + i_data (row in), o_full, o_dibit, o_last.
module row_serializer
  import matrix_pkg::*;
#(
  parameter int RW = 256
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [RW-1:0] i_data,
  output logic          o_full,
  output dibit_t        o_dibit,
  output logic          o_last
);

  localparam int CW = $clog2(RW / 2);
  localparam logic [CW-1:0] LAST = CW'(RW / 2 - 1);

  logic [RW-1:0] r_shift;
  logic          r_full;
  logic [CW-1:0] r_cnt;

  logic w_last;

  assign w_last  = r_full && (r_cnt == LAST);
  assign o_full  = r_full;
  assign o_dibit = r_shift[RW-1 -: 2];
  assign o_last  = w_last;

  // The counter wraps to zero on the last dibit, so a reload
  // on that same edge starts the next row at count zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_full  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (r_full) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (i_load) begin
        r_shift <= i_data;
        r_full  <= 1'b1;
      end else if (r_full) begin
        r_shift <= {r_shift[RW-3:0], 2'b00};
        if (w_last) begin
          r_full <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/matrix_streamer.sv
// Streams NUM_ROWS rows of RW bits out as 2-bit dibits, gap-free.
// Ports: start/busy/done/underrun control, row_* handshake in, axiov/axiod out.
module matrix_streamer
  import matrix_pkg::*;
#(
  parameter int ELEMENT_SIZE = matrix_pkg::DEF_ELEMENT_SIZE,
  parameter int ROW_LEN      = matrix_pkg::DEF_ROW_LEN,
  parameter int NUM_ROWS     = matrix_pkg::DEF_NUM_ROWS
) (
  input  logic                            eth_refclk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            row_valid,
  input  logic [ROW_LEN*ELEMENT_SIZE-1:0] row_data,
  output logic                            row_ready,
  output logic                            axiov,
  output dibit_t                          axiod,
  output logic                            busy,
  output logic                            done,
  output logic                            underrun
);

  localparam int RW  = ROW_LEN * ELEMENT_SIZE;
  localparam int RCW = $clog2(NUM_ROWS) + 1;
  localparam logic [RCW-1:0] NR = RCW'(NUM_ROWS);

  stream_state_t r_state;
  stream_state_t w_state_nxt;

  logic [RW-1:0]  r_stg;
  logic           r_stg_full;
  logic [RCW-1:0] r_rows_acc;
  logic [RCW-1:0] r_rows_sent;
  logic           r_done;
  logic           r_underrun;

  logic w_active;
  logic w_clear;
  logic w_ready;
  logic w_accept;
  logic w_load;
  logic w_final;
  logic w_starve;
  logic w_sh_full;
  logic w_sh_last;

  assign w_active = (r_state == ACTIVE);
  assign w_ready  = w_active && !r_stg_full && (r_rows_acc < NR);
  assign w_accept = row_valid && w_ready;

  // Staging hands over when the shifter is idle or on its
  // final dibit, which keeps consecutive rows bubble-free.
  assign w_load = w_active && r_stg_full
               && (!w_sh_full || w_sh_last);

  assign w_final = w_active && w_sh_last
                && (r_rows_sent == NR - 1'b1);

  // Starvation only counts once the frame has started,
  // so the start-up fill is not reported as an underrun.
  assign w_starve = w_active && !w_sh_full && !r_stg_full
                 && (r_rows_acc != '0) && (r_rows_sent < NR);

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = ACTIVE;
          w_clear     = 1'b1;
        end
      end
      ACTIVE: begin
        if (w_final) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge eth_refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_final;
    end
  end

  always_ff @(posedge eth_refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_stg      <= '0;
      r_stg_full <= 1'b0;
    end else if (w_clear) begin
      r_stg_full <= 1'b0;
    end else if (w_accept) begin
      r_stg      <= row_data;
      r_stg_full <= 1'b1;
    end else if (w_load) begin
      r_stg_full <= 1'b0;
    end
  end

  always_ff @(posedge eth_refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_rows_acc  <= '0;
      r_rows_sent <= '0;
      r_underrun  <= 1'b0;
    end else if (w_clear) begin
      r_rows_acc  <= '0;
      r_rows_sent <= '0;
      r_underrun  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rows_acc <= r_rows_acc + 1'b1;
      end
      if (w_active && w_sh_last) begin
        r_rows_sent <= r_rows_sent + 1'b1;
      end
      if (w_starve) begin
        r_underrun <= 1'b1;
      end
    end
  end

  row_serializer #(
    .RW(RW)
  ) u_ser (
    .clk    (eth_refclk),
    .rst_n  (rst_n),
    .i_load (w_load),
    .i_data (r_stg),
    .o_full (w_sh_full),
    .o_dibit(axiod),
    .o_last (w_sh_last)
  );

  assign row_ready = w_ready;
  assign axiov     = w_sh_full;
  assign busy      = w_active;
  assign done      = r_done;
  assign underrun  = r_underrun;

endmodule

// File: tb/tb_matrix_streamer.sv
// Scoreboard bench for matrix_streamer: directed frames with
// hand-computed dibits, gap, ignored start, mid-frame reset, start-on-done.
module tb_matrix_streamer;
  import matrix_pkg::*;

  localparam int ES    = DEF_ELEMENT_SIZE;
  localparam int RL    = DEF_ROW_LEN;
  localparam int NR    = DEF_NUM_ROWS;
  localparam int RW    = RL * ES;
  localparam int DPR   = RW / 2;
  localparam int FRAME = NR * DPR;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          row_valid;
  logic [RW-1:0] row_data;
  logic          row_ready;
  logic          axiov;
  dibit_t        axiod;
  logic          busy;
  logic          done;
  logic          underrun;

  always #5 clk = ~clk;

  matrix_streamer #(
    .ELEMENT_SIZE(ES),
    .ROW_LEN     (RL),
    .NUM_ROWS    (NR)
  ) dut (
    .eth_refclk(clk),
    .rst_n     (rst_n),
    .start     (start),
    .row_valid (row_valid),
    .row_data  (row_data),
    .row_ready (row_ready),
    .axiov     (axiov),
    .axiod     (axiod),
    .busy      (busy),
    .done      (done),
    .underrun  (underrun)
  );

  int     n_vec;
  int     n_miss;
  dibit_t exp_q[$];
  bit     abort;
  dibit_t first4[4];
  dibit_t tail4[4];
  int     nv, bub, nd, lat;
  logic   busy_at_done;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Mode 0: every element of row r is r+1.
  // Mode 1: mixed pattern, row 0 k=0 is B4 and k=31 is 1E.
  function automatic logic [RW-1:0] make_row(input int mode, input int r);
    logic [RW-1:0] d;
    logic [7:0]    e;
    d = '0;
    for (int k = 0; k < RL; k++) begin
      if (mode == 0) e = 8'(r + 1);
      else e = 8'(r * 37 + k * 11 + 5);
      if (mode == 1 && r == 0 && k == 0) e = 8'hB4;
      if (mode == 1 && r == 0 && k == RL - 1) e = 8'h1E;
      d[RW-1-k*ES -: ES] = e;
    end
    return d;
  endfunction

  task automatic push_row(input logic [RW-1:0] d);
    for (int i = 0; i < DPR; i++) begin
      exp_q.push_back(d[RW-1-2*i -: 2]);
    end
  endtask

  // Called at a negedge; returns at a negedge after acceptance.
  task automatic drive_row(input int mode, input int r,
                           input int lo_in, output bit ok);
    logic [RW-1:0] d;
    int lo;
    d  = make_row(mode, r);
    lo = lo_in;
    ok = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      if (abort) break;
      if (lo > 0) begin
        row_valid = 1'b0;
        if (row_ready) lo--;
      end else begin
        row_valid = 1'b1;
        row_data  = d;
        if (row_ready) begin
          push_row(d);
          ok = 1'b1;
          @(posedge clk);
          @(negedge clk);
          break;
        end
      end
      @(negedge clk);
    end
    row_valid = 1'b0;
    if (!abort) chk("row_accept", 32'(ok), 1);
  endtask

  task automatic drive_frame(input int mode, input int gap_row,
                             input int gap_d);
    bit ok;
    for (int r = 0; r < NR; r++) begin
      drive_row(mode, r, (r == gap_row) ? gap_d : 0, ok);
      if (!ok) break;
    end
  endtask

  // act 1: pulse start at dibit 'at'; act 2: reset at dibit 'at';
  // act 3: raise start on the done cycle and return.
  task automatic observe(input int act, input int at);
    int  post;
    bit  seen;
    nv = 0; bub = 0; nd = 0; lat = -1;
    seen = 1'b0; post = 0; busy_at_done = 1'bx;
    for (int t = 0; t < FRAME + 300; t++) begin
      if (act == 1 && start) start = 1'b0;
      if (axiov) begin
        if (!seen) begin
          lat  = t;
          seen = 1'b1;
          chk("busy_first_dibit", 32'(busy), 1);
        end
        if (nv < 4) first4[nv] = axiod;
        if (nv >= 124 && nv < 128) tail4[nv-124] = axiod;
        nv++;
        if (act == 1 && nv == at) start = 1'b1;
        if (act == 2 && nv == at) begin
          abort = 1'b1;
          #2 rst_n = 1'b0;
          #1;
          chk("rst_axiov", 32'(axiov), 0);
          chk("rst_axiod", 32'(axiod), 0);
          chk("rst_row_ready", 32'(row_ready), 0);
          chk("rst_busy", 32'(busy), 0);
          chk("rst_done", 32'(done), 0);
          chk("rst_underrun", 32'(underrun), 0);
          return;
        end
      end else if (seen && busy) begin
        bub++;
      end
      if (done) begin
        nd++;
        if (nd == 1) begin
          busy_at_done = busy;
          if (act == 3) begin
            start = 1'b1;
            return;
          end
        end
      end
      if (nd > 0) post++;
      if (post > 5) break;
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin : monitor
    dibit_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
      end else if (axiov) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_miss++;
          $display("FAIL sb_extra: got dibit %0d expected none", axiod);
        end else begin
          e = exp_q.pop_front();
          if (axiod !== e) begin
            n_miss++;
            $display("FAIL sb_dibit: got %0d expected %0d", axiod, e);
          end
        end
      end
    end
  end

  initial begin : main
    n_vec = 0; n_miss = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    row_valid = 1'b0; row_data = '0;
    repeat (3) @(negedge clk);
    chk("init_axiov", 32'(axiov), 0);
    chk("init_axiod", 32'(axiod), 0);
    chk("init_row_ready", 32'(row_ready), 0);
    chk("init_busy", 32'(busy), 0);
    chk("init_done", 32'(done), 0);
    chk("init_underrun", 32'(underrun), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Frame A: rows of r+1, source always valid
    pulse_start();
    chk("A_busy", 32'(busy), 1);
    chk("A_ready_first", 32'(row_ready), 1);
    fork
      drive_frame(0, -1, 0);
      observe(0, 0);
    join
    chk("A_dibits", 32'(nv), FRAME);
    chk("A_bubbles", 32'(bub), 0);
    chk("A_done_cnt", 32'(nd), 1);
    chk("A_latency", 32'(lat), 2);
    chk("A_busy_at_done", 32'(busy_at_done), 0);
    chk("A_underrun", 32'(underrun), 0);
    chk("A_first4", 32'({first4[0], first4[1], first4[2], first4[3]}),
        32'h01);

    // Frame B: B4 lead element, gap before row 5, stray start
    pulse_start();
    fork
      drive_frame(1, 5, DPR + 8);
      observe(1, 300);
    join
    chk("B_dibits", 32'(nv), FRAME);
    chk("B_gap", 32'(bub), 10);
    chk("B_done_cnt", 32'(nd), 1);
    chk("B_underrun_sticky", 32'(underrun), 1);
    chk("B_first4", 32'({first4[0], first4[1], first4[2], first4[3]}),
        32'hB4);
    chk("B_tail4", 32'({tail4[0], tail4[1], tail4[2], tail4[3]}),
        32'h1E);

    // Frame C: start clears underrun, reset at dibit 2000
    pulse_start();
    chk("C_underrun_clr", 32'(underrun), 0);
    fork
      drive_frame(0, -1, 0);
      observe(2, 2000);
    join
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    abort = 1'b0;
    @(negedge clk);

    // Frame D: clean after reset, start re-issued on done
    pulse_start();
    fork
      drive_frame(0, -1, 0);
      observe(3, 0);
    join
    chk("D_dibits", 32'(nv), FRAME);
    chk("D_bubbles", 32'(bub), 0);
    chk("D_done_cnt", 32'(nd), 1);
    chk("D_latency", 32'(lat), 2);
    chk("D_busy_at_done", 32'(busy_at_done), 0);
    chk("D_first4", 32'({first4[0], first4[1], first4[2], first4[3]}),
        32'h01);
    @(negedge clk);
    start = 1'b0;
    chk("E_busy", 32'(busy), 1);
    chk("E_ready_first", 32'(row_ready), 1);
    chk("E_underrun", 32'(underrun), 0);

    // Frame E: back-to-back frame with the same latency
    fork
      drive_frame(1, -1, 0);
      observe(0, 0);
    join
    chk("E_dibits", 32'(nv), FRAME);
    chk("E_bubbles", 32'(bub), 0);
    chk("E_done_cnt", 32'(nd), 1);
    chk("E_latency", 32'(lat), 2);
    chk("E_underrun_end", 32'(underrun), 0);
    chk("E_first4", 32'({first4[0], first4[1], first4[2], first4[3]}),
        32'hB4);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
